// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit accumulator CPU.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_RAM  = 3'd2,
    BUS_IR   = 3'd3,
    BUS_A    = 3'd4,
    BUS_ALU  = 3'd5
  } bus_sel_t;

  typedef enum logic [2:0] {
    ST_T0     = 3'd0,
    ST_T1     = 3'd1,
    ST_T2     = 3'd2,
    ST_T3     = 3'd3,
    ST_T4     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  // Complete control word produced by the decoder for one cycle.
  typedef struct packed {
    logic     pc_inc;
    logic     pc_ld;
    logic     mar_ld;
    logic     ir_ld;
    logic     a_ld;
    logic     b_ld;
    logic     out_ld;
    logic     flags_ld;
    logic     ram_we;
    logic     alu_sub;
    bus_sel_t bus_sel;
  } ctrl_t;

  // Final execute T-state of each instruction; undefined opcodes behave as NOP.
  function automatic state_t last_step(input opcode_t op);
    case (op)
      OP_LDA, OP_STA: return ST_T3;
      OP_ADD, OP_SUB: return ST_T4;
      default:        return ST_T2;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational map of (state, opcode, flags) to the control word.
import cpu_pkg::*;

module control_decode (
  input  state_t  i_state,
  input  opcode_t i_opcode,
  input  logic    i_carry,
  input  logic    i_zero,
  input  logic    i_active,
  output ctrl_t   o_ctrl
);

  // Decode the current T-state and opcode into strobes and bus select.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch; combinational blocks use '='.
    o_ctrl = '0;
    if (i_active) begin
      case (i_state)
        ST_T0: begin
          o_ctrl.bus_sel = BUS_PC;
          o_ctrl.mar_ld  = 1'b1;
        end
        ST_T1: begin
          o_ctrl.bus_sel = BUS_RAM;
          o_ctrl.ir_ld   = 1'b1;
          o_ctrl.pc_inc  = 1'b1;
        end
        ST_T2: begin
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              o_ctrl.bus_sel = BUS_IR;
              o_ctrl.mar_ld  = 1'b1;
            end
            OP_LDI: begin
              o_ctrl.bus_sel = BUS_IR;
              o_ctrl.a_ld    = 1'b1;
            end
            OP_JMP: begin
              o_ctrl.bus_sel = BUS_IR;
              o_ctrl.pc_ld   = 1'b1;
            end
            OP_JC: begin
              if (i_carry) begin
                o_ctrl.bus_sel = BUS_IR;
                o_ctrl.pc_ld   = 1'b1;
              end
            end
            OP_JZ: begin
              if (i_zero) begin
                o_ctrl.bus_sel = BUS_IR;
                o_ctrl.pc_ld   = 1'b1;
              end
            end
            OP_OUT: begin
              o_ctrl.bus_sel = BUS_A;
              o_ctrl.out_ld  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T3: begin
          case (i_opcode)
            OP_LDA: begin
              o_ctrl.bus_sel = BUS_RAM;
              o_ctrl.a_ld    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              o_ctrl.bus_sel = BUS_RAM;
              o_ctrl.b_ld    = 1'b1;
            end
            OP_STA: begin
              o_ctrl.bus_sel = BUS_A;
              o_ctrl.ram_we  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T4: begin
          if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            o_ctrl.bus_sel  = BUS_ALU;
            o_ctrl.a_ld     = 1'b1;
            o_ctrl.flags_ld = 1'b1;
            o_ctrl.alu_sub  = (i_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: holds the state register and next-state logic and
// drives the datapath strobes through control_decode.
import cpu_pkg::*;

module control_sequencer (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_ir,
  input  logic              i_carry,
  input  logic              i_zero,
  output logic              o_pc_inc,
  output logic              o_pc_ld,
  output logic              o_mar_ld,
  output logic              o_ir_ld,
  output logic              o_a_ld,
  output logic              o_b_ld,
  output logic              o_out_ld,
  output logic              o_flags_ld,
  output logic              o_ram_we,
  output logic              o_alu_sub,
  output logic [2:0]        o_bus_sel,
  output logic [2:0]        o_tstate,
  output logic              o_halted
);

  state_t  r_state;
  state_t  w_next;
  opcode_t w_opcode;
  ctrl_t   w_ctrl;
  logic    w_active;
  logic    w_unused_operand;

  assign w_opcode = opcode_t'(i_ir[DATA_W-1 -: OPC_W]);
  // The operand nibble reaches the bus through the datapath, not this block.
  assign w_unused_operand = ^i_ir[OPC_W-1:0];
  // Reset must silence strobes without waiting for a clock edge.
  assign w_active = i_en & ~i_rst;

  // Advance through fetch/execute; the last step of an instruction returns to T0.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_T0: w_next = ST_T1;
      ST_T1: w_next = ST_T2;
      ST_T2, ST_T3, ST_T4: begin
        if (r_state == last_step(w_opcode))
          w_next = (w_opcode == OP_HLT) ? ST_HALTED : ST_T0;
        else
          w_next = state_t'(r_state + 3'd1);
      end
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_T0;
    endcase
  end

  // State register; frozen while disabled, only reset leaves HALTED.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses '<=' so every flop samples pre-edge values.
    if (i_rst)
      r_state <= ST_T0;
    else if (i_en)
      r_state <= w_next;
  end

  control_decode u_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_carry  (i_carry),
    .i_zero   (i_zero),
    .i_active (w_active),
    .o_ctrl   (w_ctrl)
  );

  assign o_pc_inc   = w_ctrl.pc_inc;
  assign o_pc_ld    = w_ctrl.pc_ld;
  assign o_mar_ld   = w_ctrl.mar_ld;
  assign o_ir_ld    = w_ctrl.ir_ld;
  assign o_a_ld     = w_ctrl.a_ld;
  assign o_b_ld     = w_ctrl.b_ld;
  assign o_out_ld   = w_ctrl.out_ld;
  assign o_flags_ld = w_ctrl.flags_ld;
  assign o_ram_we   = w_ctrl.ram_we;
  assign o_alu_sub  = w_ctrl.alu_sub;
  assign o_bus_sel  = w_ctrl.bus_sel;
  assign o_tstate   = (r_state == ST_HALTED) ? 3'd0 : r_state;
  assign o_halted   = (r_state == ST_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer.
module tb_control_sequencer;

  logic       clk, rst, en, carry, zero;
  logic [7:0] ir;
  logic       pc_inc, pc_ld, mar_ld, ir_ld, a_ld, b_ld, out_ld, flags_ld, ram_we, alu_sub;
  logic [2:0] bus_sel, tstate;
  logic       halted;

  control_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_ir       (ir),
    .i_carry    (carry),
    .i_zero     (zero),
    .o_pc_inc   (pc_inc),
    .o_pc_ld    (pc_ld),
    .o_mar_ld   (mar_ld),
    .o_ir_ld    (ir_ld),
    .o_a_ld     (a_ld),
    .o_b_ld     (b_ld),
    .o_out_ld   (out_ld),
    .o_flags_ld (flags_ld),
    .o_ram_we   (ram_we),
    .o_alu_sub  (alu_sub),
    .o_bus_sel  (bus_sel),
    .o_tstate   (tstate),
    .o_halted   (halted)
  );

  // Strobe bit order: pc_inc pc_ld mar_ld ir_ld a_ld b_ld out_ld flags_ld ram_we alu_sub
  localparam logic [9:0] S_NONE  = 10'b0000000000;
  localparam logic [9:0] S_PCINC = 10'b1000000000;
  localparam logic [9:0] S_PCLD  = 10'b0100000000;
  localparam logic [9:0] S_MAR   = 10'b0010000000;
  localparam logic [9:0] S_IR    = 10'b0001000000;
  localparam logic [9:0] S_A     = 10'b0000100000;
  localparam logic [9:0] S_B     = 10'b0000010000;
  localparam logic [9:0] S_OUT   = 10'b0000001000;
  localparam logic [9:0] S_FLG   = 10'b0000000100;
  localparam logic [9:0] S_WE    = 10'b0000000010;
  localparam logic [9:0] S_SUB   = 10'b0000000001;

  typedef struct {
    logic       en;
    logic [7:0] ir;
    logic       c;
    logic       z;
    logic [9:0] st;
    logic [2:0] bus;
    logic [2:0] ts;
    logic       h;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] actual();
    return {pc_inc, pc_ld, mar_ld, ir_ld, a_ld, b_ld, out_ld, flags_ld, ram_we, alu_sub,
            bus_sel, tstate, halted};
  endfunction

  function automatic logic [16:0] pack(input logic [9:0] st, input logic [2:0] bus,
                                       input logic [2:0] ts, input logic h);
    return {st, bus, ts, h};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got strobes=%b bus=%0d ts=%0d halt=%b, expected strobes=%b bus=%0d ts=%0d halt=%b",
               name, got[16:7], got[6:4], got[3:1], got[0], exp[16:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic addv(input logic e, input logic [7:0] i, input logic c, input logic z,
                      input logic [9:0] st, input logic [2:0] bus, input logic [2:0] ts,
                      input logic h);
    vec_t v;
    v.en = e; v.ir = i; v.c = c; v.z = z; v.st = st; v.bus = bus; v.ts = ts; v.h = h;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [7:0] i);
    addv(1, i, 0, 0, S_MAR, 3'd1, 3'd0, 0);
    addv(1, i, 0, 0, S_IR | S_PCINC, 3'd2, 3'd1, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ir = 8'h00; carry = 1'b0; zero = 1'b0;

    // LDI then OUT: 3 cycles each
    fetch(8'h57); addv(1, 8'h57, 0, 0, S_A, 3'd3, 3'd2, 0);
    fetch(8'hE0); addv(1, 8'hE0, 0, 0, S_OUT, 3'd4, 3'd2, 0);
    // ADD and SUB: 5 cycles
    fetch(8'h2A);
    addv(1, 8'h2A, 0, 0, S_MAR, 3'd3, 3'd2, 0);
    addv(1, 8'h2A, 0, 0, S_B, 3'd2, 3'd3, 0);
    addv(1, 8'h2A, 0, 0, S_A | S_FLG, 3'd5, 3'd4, 0);
    fetch(8'h3A);
    addv(1, 8'h3A, 0, 0, S_MAR, 3'd3, 3'd2, 0);
    addv(1, 8'h3A, 0, 0, S_B, 3'd2, 3'd3, 0);
    addv(1, 8'h3A, 0, 0, S_A | S_FLG | S_SUB, 3'd5, 3'd4, 0);
    // STA: 4 cycles
    fetch(8'h4C);
    addv(1, 8'h4C, 0, 0, S_MAR, 3'd3, 3'd2, 0);
    addv(1, 8'h4C, 0, 0, S_WE, 3'd4, 3'd3, 0);
    // Jumps, taken and not taken
    fetch(8'h61); addv(1, 8'h61, 0, 0, S_PCLD, 3'd3, 3'd2, 0);
    fetch(8'h73); addv(1, 8'h73, 0, 1, S_NONE, 3'd0, 3'd2, 0);
    fetch(8'h73); addv(1, 8'h73, 1, 0, S_PCLD, 3'd3, 3'd2, 0);
    fetch(8'h83); addv(1, 8'h83, 1, 0, S_NONE, 3'd0, 3'd2, 0);
    fetch(8'h83); addv(1, 8'h83, 0, 1, S_PCLD, 3'd3, 3'd2, 0);
    // NOP and an undefined opcode
    fetch(8'h00); addv(1, 8'h00, 0, 0, S_NONE, 3'd0, 3'd2, 0);
    fetch(8'h9A); addv(1, 8'h9A, 0, 0, S_NONE, 3'd0, 3'd2, 0);
    // LDA with a 4-cycle stall in T3
    fetch(8'h1B);
    addv(1, 8'h1B, 0, 0, S_MAR, 3'd3, 3'd2, 0);
    for (int k = 0; k < 4; k++) addv(0, 8'h1B, 0, 0, S_NONE, 3'd0, 3'd3, 0);
    addv(1, 8'h1B, 0, 0, S_A, 3'd2, 3'd3, 0);
    // HLT then 20 silent cycles
    fetch(8'hF0); addv(1, 8'hF0, 0, 0, S_NONE, 3'd0, 3'd2, 0);
    for (int k = 0; k < 20; k++) addv(1, 8'hF0, 0, 0, S_NONE, 3'd0, 3'd0, 1);

    // Reset state, including across a clock edge with enable high
    #2;
    check("reset_idle", actual(), pack(S_NONE, 3'd0, 3'd0, 0));
    en = 1'b1;
    #1;
    check("reset_en", actual(), pack(S_NONE, 3'd0, 3'd0, 0));
    @(posedge clk); #1;
    check("reset_edge", actual(), pack(S_NONE, 3'd0, 3'd0, 0));
    rst = 1'b0;

    // Table-driven run
    foreach (vecs[i]) begin
      en = vecs[i].en; ir = vecs[i].ir; carry = vecs[i].c; zero = vecs[i].z;
      @(negedge clk);
      check($sformatf("vec%0d_ir%02h", i, vecs[i].ir), actual(),
            pack(vecs[i].st, vecs[i].bus, vecs[i].ts, vecs[i].h));
      @(posedge clk); #1;
    end

    // Asynchronous exit from HALTED
    en = 1'b1;
    check("halted_before_rst", actual(), pack(S_NONE, 3'd0, 3'd0, 1));
    #2 rst = 1'b1;
    #1;
    check("halted_async_rst", actual(), pack(S_NONE, 3'd0, 3'd0, 0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-ADD in T3
    ir = 8'h2A;
    @(negedge clk);
    check("add_t0", actual(), pack(S_MAR, 3'd1, 3'd0, 0));
    repeat (3) @(posedge clk);
    #1;
    check("add_t3", actual(), pack(S_B, 3'd2, 3'd3, 0));
    rst = 1'b1;
    #1;
    check("add_t3_rst", actual(), pack(S_NONE, 3'd0, 3'd0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_t0", actual(), pack(S_MAR, 3'd1, 3'd0, 0));
    @(posedge clk); #1;
    check("post_rst_t1", actual(), pack(S_IR | S_PCINC, 3'd2, 3'd1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
